// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator. Produces raster coordinates for
// an upstream pixel source. Delays sync/blanking by the source's fixed latency
// and registers the final colour, sync and display-enable outputs.
//
// Strobe semantics: en is a pixel strobe, not a handshake. Every register in
// this block (counters, delay line, outputs) advances only on a clk_in edge
// with en=1 and holds otherwise. rst overrides en.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic               pattern_en,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic [11:0]        x,
  output logic [11:0]        y,
  output logic               de_req,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // One delay-line entry: everything the output stage needs about a pixel
  // position except the colour data, which arrives from the pixel source.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] bar;
  } stage_t;

  stage_t     raw_stage;
  stage_t     tap;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;

  // Raster counters: x sweeps the line, y steps when x wraps.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == H_LAST) begin
        x <= '0;
        if (y == V_LAST) y <= '0;
        else             y <= y + 12'd1;
      end else begin
        x <= x + 12'd1;
      end
    end
  end

  // Region decode straight from the counters; 13-bit compares keep a
  // 4096-wide raster from aliasing its boundaries to zero.
  always_comb begin
    de_req      = ({1'b0, x} < 13'(H_ACTIVE)) && ({1'b0, y} < 13'(V_ACTIVE));
    hs_raw      = ({1'b0, x} >= 13'(H_ACTIVE + H_FP)) &&
                  ({1'b0, x} <  13'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw      = ({1'b0, y} >= 13'(V_ACTIVE + V_FP)) &&
                  ({1'b0, y} <  13'(V_ACTIVE + V_FP + V_SYNC));
    bar_idx     = 3'(({3'b000, x} << 3) / 15'(H_ACTIVE));
    line_start  = en && (x == 12'd0);
    frame_start = en && (x == 12'd0) && (y == 12'd0);
    raw_stage   = '{hs: hs_raw, vs: vs_raw, de: de_req, bar: bar_idx};
  end

  // Delay line: the output register itself is the last of the PIPE_LAT+1
  // stages, so only PIPE_LAT registered entries live here.
  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign tap = raw_stage;
    end else begin : g_delay
      stage_t dly_q [PIPE_LAT];

      // Shift the pixel attributes along with the source's read latency.
      always_ff @(posedge clk_in) begin
        if (rst) begin
          for (int i = 0; i < PIPE_LAT; i++) dly_q[i] <= '0;
        end else if (en) begin
          dly_q[0] <= raw_stage;
          for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign tap = dly_q[PIPE_LAT-1];
    end
  endgenerate

  // Colour-bar palette as {r,g,b}, in the usual bar order
  // white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    bar_rgb = 3'b000;
    case (tap.bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  // Output register: sync at configured polarity, colour forced to zero
  // outside the active area, test pattern selected per en-cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      de     <= 1'b0;
      h_sync <= ~H_POL;
      v_sync <= ~V_POL;
      r      <= '0;
      g      <= '0;
      b      <= '0;
    end else if (en) begin
      de     <= tap.de;
      h_sync <= tap.hs ? H_POL : ~H_POL;
      v_sync <= tap.vs ? V_POL : ~V_POL;
      if (!tap.de) begin
        r <= '0;
        g <= '0;
        b <= '0;
      end else if (pattern_en) begin
        r <= {COLOR_W{bar_rgb[2]}};
        g <= {COLOR_W{bar_rgb[1]}};
        b <= {COLOR_W{bar_rgb[0]}};
      end else begin
        r <= r_in;
        g <= g_in;
        b <= b_in;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench for vga_timing_gen. The reference model
// tracks only "number of en-cycles since reset" and derives raster position,
// regions, latency and colours from it with plain arithmetic.
module tb_vga_timing_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int CW = 8, PL = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int W  = 12 + 12 + 3 + 3 + 3 * CW;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, pattern_en;
  logic [CW-1:0] r_in, g_in, b_in;
  logic [11:0]   x, y;
  logic          de_req, h_sync, v_sync, de, line_start, frame_start;
  logic [CW-1:0] r, g, b;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .COLOR_W(CW), .PIPE_LAT(PL)
  ) dut (
    .clk_in(clk), .rst(rst), .en(en), .pattern_en(pattern_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .x(x), .y(y), .de_req(de_req), .r(r), .g(g), .b(b),
    .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .line_start(line_start), .frame_start(frame_start)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state: en-cycles since reset plus the registered outputs
  int            n;
  logic          m_de, m_hs, m_vs;
  logic [CW-1:0] m_r, m_g, m_b;

  function automatic int px(input int k);
    return k % HT;
  endfunction

  function automatic int py(input int k);
    return (k / HT) % VT;
  endfunction

  // Named bar colours as {r,g,b}
  function automatic logic [2:0] bar_colour(input int idx);
    case (idx)
      0:       return 3'b111; // white
      1:       return 3'b110; // yellow
      2:       return 3'b011; // cyan
      3:       return 3'b010; // green
      4:       return 3'b101; // magenta
      5:       return 3'b100; // red
      6:       return 3'b001; // blue
      default: return 3'b000; // black
    endcase
  endfunction

  task automatic model_reset();
    n    = 0;
    m_de = 1'b0;
    m_hs = ~HP;
    m_vs = ~VP;
    m_r  = '0;
    m_g  = '0;
    m_b  = '0;
  endtask

  // Effect of one clock edge on the model
  task automatic model_edge(input logic r_, input logic en_, input logic pat,
                            input logic [CW-1:0] gi, input logic [CW-1:0] bi);
    int m, mx, my;
    logic act, hs_on, vs_on;
    logic [2:0] c;
    if (r_) begin
      model_reset();
    end else if (en_) begin
      m = n - PL;
      if (m < 0) begin
        m_de = 1'b0; m_hs = ~HP; m_vs = ~VP;
        m_r = '0; m_g = '0; m_b = '0;
      end else begin
        mx    = px(m);
        my    = py(m);
        act   = (mx < HA) && (my < VA);
        hs_on = (mx >= HA + HF) && (mx < HA + HF + HS);
        vs_on = (my >= VA + VF) && (my < VA + VF + VS);
        m_de  = act;
        m_hs  = hs_on ? HP : ~HP;
        m_vs  = vs_on ? VP : ~VP;
        if (!act) begin
          m_r = '0; m_g = '0; m_b = '0;
        end else if (pat) begin
          c   = bar_colour(mx * 8 / HA);
          m_r = {CW{c[2]}};
          m_g = {CW{c[1]}};
          m_b = {CW{c[0]}};
        end else begin
          m_r = CW'(mx);
          m_g = gi;
          m_b = bi;
        end
      end
      n++;
    end
  endtask

  function automatic logic [W-1:0] expected_now(input logic en_);
    logic dreq, ls, fs;
    dreq = (px(n) < HA) && (py(n) < VA);
    ls   = en_ && (px(n) == 0);
    fs   = en_ && ((n % FT) == 0);
    return {12'(px(n)), 12'(py(n)), dreq, ls, fs, m_de, m_hs, m_vs, m_r, m_g, m_b};
  endfunction

  // Driver: one cycle of stimulus; the source returns r_in = x of the pixel
  // requested PL en-cycles earlier.
  task automatic drive_cycle(input logic r_, input logic en_, input logic pat);
    @(negedge clk);
    rst        = r_;
    en         = en_;
    pattern_en = pat;
    r_in       = (n - PL >= 0) ? CW'(px(n - PL)) : CW'($urandom);
    g_in       = CW'($urandom);
    b_in       = CW'($urandom);
    exp_q.push_back(expected_now(en_));
    model_edge(r_, en_, pat, g_in, b_in);
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {x, y, de_req, line_start, frame_start, de, h_sync, v_sync, r, g, b};
        n_vec++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got x=%0d y=%0d dreq=%b ls=%b fs=%b de=%b hs=%b vs=%b rgb=%h/%h/%h required x=%0d y=%0d dreq=%b ls=%b fs=%b de=%b hs=%b vs=%b rgb=%h/%h/%h",
                   $time, a[W-1 -: 12], a[W-13 -: 12], a[W-25], a[W-26], a[W-27],
                   a[W-28], a[W-29], a[W-30], a[3*CW-1 -: CW], a[2*CW-1 -: CW], a[CW-1:0],
                   e[W-1 -: 12], e[W-13 -: 12], e[W-25], e[W-26], e[W-27],
                   e[W-28], e[W-29], e[W-30], e[3*CW-1 -: CW], e[2*CW-1 -: CW], e[CW-1:0]);
        end
      end
    end
  end

  // Stimulus sequence and final report
  initial begin
    logic pat;
    rst = 1'b1; en = 1'b1; pattern_en = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset held with en=1
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0);

    // Free-running pass-through over a full frame and its wrap
    repeat (FT + 200) drive_cycle(1'b0, 1'b1, 1'b0);

    // Throttled: en alternating, colour bars on
    for (int i = 0; i < 2 * HT + 50; i++) drive_cycle(1'b0, (i % 2) == 0, 1'b1);

    // Run to (300,2), then reset mid-frame
    for (int i = 0; i < FT && !(px(n) == 300 && py(n) == 2); i++)
      drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);

    // Random en and pattern_en, with a reset issued while en=0
    pat = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 63) == 0) pat = ~pat;
      if (i == 2500) drive_cycle(1'b1, 1'b0, pat);
      else           drive_cycle(1'b0, $urandom_range(0, 3) != 0, pat);
    end

    // Colour bars at full rate across a couple of lines
    repeat (2 * HT + 20) drive_cycle(1'b0, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    #5;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
